// File: rtl/sram_ctrl.sv
// Dual-bank asynchronous-SRAM controller: per-operation wait states, byte lanes,
// a write hold cycle and a registered read-data path. Address MSB selects the bank.
module sram_ctrl #(
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ack,
    output logic                  busy,
    output logic [ADDR_W-2:0]     base_addr,
    output logic [ADDR_W-2:0]     ext_addr,
    inout  wire  [DATA_W-1:0]     base_data,
    inout  wire  [DATA_W-1:0]     ext_data,
    output logic                  base_ce_n,
    output logic                  base_oe_n,
    output logic                  base_we_n,
    output logic                  ext_ce_n,
    output logic                  ext_oe_n,
    output logic                  ext_we_n,
    output logic [DATA_W/8-1:0]   base_be_n,
    output logic [DATA_W/8-1:0]   ext_be_n
);
    localparam int BE_W     = DATA_W / 8;
    localparam int RD_EFF   = (RD_WAIT < 1) ? 1 : RD_WAIT;
    localparam int WR_EFF   = (WR_WAIT < 1) ? 1 : WR_WAIT;
    localparam int MAX_WAIT = (RD_EFF > WR_EFF) ? RD_EFF : WR_EFF;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_EFF - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_EFF - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_we_q, op_we_d;
    logic                sel_q, sel_d;
    logic [ADDR_W-2:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                base_ce_n_q, base_ce_n_d, base_oe_n_q, base_oe_n_d;
    logic                base_we_n_q, base_we_n_d, ext_ce_n_q, ext_ce_n_d;
    logic                ext_oe_n_q, ext_oe_n_d, ext_we_n_q, ext_we_n_d;
    logic [BE_W-1:0]     base_be_n_q, base_be_n_d, ext_be_n_q, ext_be_n_d;
    logic                base_drv_q, base_drv_d, ext_drv_q, ext_drv_d;
    logic                ce_n_d, oe_n_d, we_n_d, drv_d;
    logic [BE_W-1:0]     be_n_d;

    // Handshake: req is sampled only while busy=0 (IDLE); a req seen while busy is
    // dropped, not queued. ack pulses for one cycle, and that cycle is IDLE, so a
    // req held alongside ack is accepted with no gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    op_we_d = we;
                    sel_d   = addr[ADDR_W-1];
                    addr_d  = addr[ADDR_W-2:0];
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = we ? WR_LOAD : RD_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (op_we_q) begin
                        state_d = HOLD;
                    end else begin
                        rdata_d = sel_q ? ext_data : base_data;
                        ack_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are derived from the next state so they leave the flops already
    // aligned with the cycle they belong to; a zero byte mask never pulses we_n.
    always_comb begin
        ce_n_d = (state_d == IDLE);
        oe_n_d = !((state_d == ACCESS) && !op_we_d);
        we_n_d = !((state_d == ACCESS) && op_we_d && (|be_d));
        drv_d  = (state_d != IDLE) && op_we_d;
        if (state_d == IDLE) begin
            be_n_d = '1;
        end else if (op_we_d) begin
            be_n_d = ~be_d;
        end else begin
            be_n_d = '0;
        end
        base_ce_n_d = ce_n_d | sel_d;
        base_oe_n_d = oe_n_d | sel_d;
        base_we_n_d = we_n_d | sel_d;
        base_be_n_d = be_n_d | {BE_W{sel_d}};
        base_drv_d  = drv_d & ~sel_d;
        ext_ce_n_d  = ce_n_d | ~sel_d;
        ext_oe_n_d  = oe_n_d | ~sel_d;
        ext_we_n_d  = we_n_d | ~sel_d;
        ext_be_n_d  = be_n_d | {BE_W{~sel_d}};
        ext_drv_d   = drv_d & sel_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            base_ce_n_q <= 1'b1;
            base_oe_n_q <= 1'b1;
            base_we_n_q <= 1'b1;
            base_be_n_q <= '1;
            base_drv_q  <= 1'b0;
            ext_ce_n_q  <= 1'b1;
            ext_oe_n_q  <= 1'b1;
            ext_we_n_q  <= 1'b1;
            ext_be_n_q  <= '1;
            ext_drv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            base_ce_n_q <= base_ce_n_d;
            base_oe_n_q <= base_oe_n_d;
            base_we_n_q <= base_we_n_d;
            base_be_n_q <= base_be_n_d;
            base_drv_q  <= base_drv_d;
            ext_ce_n_q  <= ext_ce_n_d;
            ext_oe_n_q  <= ext_oe_n_d;
            ext_we_n_q  <= ext_we_n_d;
            ext_be_n_q  <= ext_be_n_d;
            ext_drv_q   <= ext_drv_d;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign busy      = (state_q != IDLE);
    assign base_addr = addr_q;
    assign ext_addr  = addr_q;
    assign base_ce_n = base_ce_n_q;
    assign base_oe_n = base_oe_n_q;
    assign base_we_n = base_we_n_q;
    assign base_be_n = base_be_n_q;
    assign ext_ce_n  = ext_ce_n_q;
    assign ext_oe_n  = ext_oe_n_q;
    assign ext_we_n  = ext_we_n_q;
    assign ext_be_n  = ext_be_n_q;
    assign base_data = base_drv_q ? wdata_q : 'z;
    assign ext_data  = ext_drv_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: chip models on both banks, a reference memory, directed
// timing scenarios and randomized traffic; also a slow-wait-state instance.
module tb_sram_ctrl;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] be = '0;
    logic [DW-1:0] rdata;
    logic ack, busy;
    logic [AW-2:0] base_addr, ext_addr;
    wire  [DW-1:0] base_data, ext_data;
    logic base_ce_n, base_oe_n, base_we_n, ext_ce_n, ext_oe_n, ext_we_n;
    logic [BW-1:0] base_be_n, ext_be_n;

    logic s_req = 1'b0, s_we = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_wdata = '0;
    logic [BW-1:0] s_be = '0;
    logic [DW-1:0] s_rdata;
    logic s_ack, s_busy;
    logic [AW-2:0] s_base_addr, s_ext_addr;
    wire  [DW-1:0] s_base_data, s_ext_data;
    logic s_base_ce_n, s_base_oe_n, s_base_we_n, s_ext_ce_n, s_ext_oe_n, s_ext_we_n;
    logic [BW-1:0] s_base_be_n, s_ext_be_n;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] base_mem [256];
    logic [DW-1:0] ext_mem [256];
    logic [DW-1:0] ref_mem [2][256];
    logic [DW-1:0] exp_rdata = '0;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(1), .WR_WAIT(1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata), .ack(ack), .busy(busy), .base_addr(base_addr), .ext_addr(ext_addr),
        .base_data(base_data), .ext_data(ext_data),
        .base_ce_n(base_ce_n), .base_oe_n(base_oe_n), .base_we_n(base_we_n),
        .ext_ce_n(ext_ce_n), .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n),
        .base_be_n(base_be_n), .ext_be_n(ext_be_n)
    );

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(3), .WR_WAIT(2)) u_slow (
        .clk(clk), .rst(rst), .req(s_req), .we(s_we), .addr(s_addr), .wdata(s_wdata), .be(s_be),
        .rdata(s_rdata), .ack(s_ack), .busy(s_busy), .base_addr(s_base_addr), .ext_addr(s_ext_addr),
        .base_data(s_base_data), .ext_data(s_ext_data),
        .base_ce_n(s_base_ce_n), .base_oe_n(s_base_oe_n), .base_we_n(s_base_we_n),
        .ext_ce_n(s_ext_ce_n), .ext_oe_n(s_ext_oe_n), .ext_we_n(s_ext_we_n),
        .base_be_n(s_base_be_n), .ext_be_n(s_ext_be_n)
    );

    // Asynchronous SRAM chip models: drive on a read strobe, capture enabled lanes on write.
    assign base_data = (!base_ce_n && !base_oe_n && base_we_n) ? base_mem[base_addr[7:0]] : 'z;
    assign ext_data  = (!ext_ce_n && !ext_oe_n && ext_we_n) ? ext_mem[ext_addr[7:0]] : 'z;
    assign s_base_data = (!s_base_ce_n && !s_base_oe_n) ? (32'h5A5A_0000 | 32'(s_base_addr[7:0])) : 'z;

    always @(posedge clk) begin
        for (int i = 0; i < BW; i++) begin
            if (!base_ce_n && !base_we_n && !base_be_n[i])
                base_mem[base_addr[7:0]][8*i +: 8] <= base_data[8*i +: 8];
            if (!ext_ce_n && !ext_we_n && !ext_be_n[i])
                ext_mem[ext_addr[7:0]][8*i +: 8] <= ext_data[8*i +: 8];
        end
    end

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        for (int i = 0; i < BW; i++)
            if (b[i]) ref_mem[a[AW-1]][a[7:0]][8*i +: 8] = d[8*i +: 8];
    endtask

    // Driver: present one request and wait (bounded) for its ack; returns latency and rdata.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b, output int lat, output logic [DW-1:0] rd);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = -1; rd = '0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (ack) begin
                lat = c; rd = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({ack, busy} !== 2'b00) begin $display("FAIL reset_ack_busy: got %b want 00", {ack, busy}); n_fail++; end
        n_checks++; if (rdata !== '0) begin $display("FAIL reset_rdata: got %h want 0", rdata); n_fail++; end
        n_checks++; if ({base_ce_n, base_oe_n, base_we_n, base_be_n, ext_ce_n, ext_oe_n, ext_we_n, ext_be_n} !== 14'h3FFF) begin
            $display("FAIL reset_strobes: got %h want 3fff", {base_ce_n, base_oe_n, base_we_n, base_be_n, ext_ce_n, ext_oe_n, ext_we_n, ext_be_n}); n_fail++; end
        n_checks++; if ({base_addr, ext_addr} !== '0) begin $display("FAIL reset_addr: got %h/%h want 0", base_addr, ext_addr); n_fail++; end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_base();
        req = 1'b1; we = 1'b1; addr = 21'h00010; wdata = 32'hDEADBEEF; be = 4'hF;
        @(posedge clk); #1; req = 1'b0;
        n_checks++; if ({base_ce_n, base_oe_n, base_we_n, base_be_n} !== 7'b0100000) begin
            $display("FAIL wr_c1_base: got %b want 0100000", {base_ce_n, base_oe_n, base_we_n, base_be_n}); n_fail++; end
        n_checks++; if ({ext_ce_n, ext_oe_n, ext_we_n, ext_be_n} !== 7'h7F) begin
            $display("FAIL wr_c1_ext: got %b want 1111111", {ext_ce_n, ext_oe_n, ext_we_n, ext_be_n}); n_fail++; end
        n_checks++; if (base_data !== 32'hDEADBEEF) begin $display("FAIL wr_c1_bus: got %h want deadbeef", base_data); n_fail++; end
        n_checks++; if ({base_addr, ack, busy} !== {20'h00010, 2'b01}) begin
            $display("FAIL wr_c1_addr: got %h/%b%b want 00010/01", base_addr, ack, busy); n_fail++; end
        @(posedge clk); #1;
        n_checks++; if ({base_ce_n, base_we_n, ack, ext_ce_n, ext_we_n} !== 5'b01011) begin
            $display("FAIL wr_c2_hold: got %b want 01011", {base_ce_n, base_we_n, ack, ext_ce_n, ext_we_n}); n_fail++; end
        n_checks++; if (base_data !== 32'hDEADBEEF) begin $display("FAIL wr_c2_bus: got %h want deadbeef", base_data); n_fail++; end
        @(posedge clk); #1;
        n_checks++; if ({ack, busy, base_ce_n} !== 3'b101) begin $display("FAIL wr_c3_ack: got %b want 101", {ack, busy, base_ce_n}); n_fail++; end
        n_checks++; if (base_data === 32'hDEADBEEF) begin $display("FAIL wr_c3_bus_release: got %h want undriven", base_data); n_fail++; end
        ref_write(21'h00010, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_read_base();
        req = 1'b1; we = 1'b0; addr = 21'h00010; wdata = $urandom; be = 4'($urandom_range(0, 15));
        @(posedge clk); #1; req = 1'b0;
        n_checks++; if ({base_ce_n, base_oe_n, base_we_n, base_be_n, ack} !== 8'b00100000) begin
            $display("FAIL rd_c1_strobes: got %b want 00100000", {base_ce_n, base_oe_n, base_we_n, base_be_n, ack}); n_fail++; end
        n_checks++; if (base_data !== ref_mem[0][8'h10]) begin $display("FAIL rd_c1_bus: got %h want %h", base_data, ref_mem[0][8'h10]); n_fail++; end
        @(posedge clk); #1;
        n_checks++; if ({ack, base_oe_n} !== 2'b11) begin $display("FAIL rd_c2_ack: got %b want 11", {ack, base_oe_n}); n_fail++; end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin $display("FAIL rd_c2_rdata: got %h want deadbeef", rdata); n_fail++; end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_ext_partial();
        int lat; logic [DW-1:0] rd;
        issue(1'b1, 21'h100020, 32'hAABBCCDD, 4'hF, lat, rd);
        ref_write(21'h100020, 32'hAABBCCDD, 4'hF);
        n_checks++; if (lat !== 3) begin $display("FAIL ext_prefill_lat: got %0d want 3", lat); n_fail++; end
        req = 1'b1; we = 1'b1; addr = 21'h100020; wdata = 32'h12345678; be = 4'h3;
        @(posedge clk); #1; req = 1'b0;
        n_checks++; if (ext_addr !== 20'h00020) begin $display("FAIL ext_addr: got %h want 00020", ext_addr); n_fail++; end
        n_checks++; if ({ext_ce_n, ext_oe_n, ext_we_n, ext_be_n} !== 7'b0101100) begin
            $display("FAIL ext_strobes: got %b want 0101100", {ext_ce_n, ext_oe_n, ext_we_n, ext_be_n}); n_fail++; end
        n_checks++; if ({base_ce_n, base_oe_n, base_we_n, base_be_n} !== 7'h7F) begin
            $display("FAIL ext_base_idle: got %b want 1111111", {base_ce_n, base_oe_n, base_we_n, base_be_n}); n_fail++; end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ack !== 1'b1) begin $display("FAIL ext_wr_ack: got %b want 1", ack); n_fail++; end
        ref_write(21'h100020, 32'h12345678, 4'h3);
        issue(1'b0, 21'h100020, '0, '0, lat, rd);
        n_checks++; if (lat !== 2 || rd !== 32'hAABB5678) begin $display("FAIL ext_readback: got %0d/%h want 2/aabb5678", lat, rd); n_fail++; end
        exp_rdata = rd;
    endtask

    task automatic test_zero_be();
        int lat; logic [DW-1:0] rd;
        req = 1'b1; we = 1'b1; addr = 21'h00030; wdata = 32'hFFFFFFFF; be = 4'h0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1; req = 1'b0;
            n_checks++; if ({base_ce_n, base_we_n, base_be_n, ack} !== 7'b0111110) begin
                $display("FAIL zbe_c%0d_strobes: got %b want 0111110", c, {base_ce_n, base_we_n, base_be_n, ack}); n_fail++; end
        end
        @(posedge clk); #1;
        n_checks++; if (ack !== 1'b1) begin $display("FAIL zbe_ack: got %b want 1", ack); n_fail++; end
        issue(1'b0, 21'h00030, '0, '0, lat, rd);
        n_checks++; if (rd !== ref_mem[0][8'h30]) begin $display("FAIL zbe_mem_untouched: got %h want %h", rd, ref_mem[0][8'h30]); n_fail++; end
        exp_rdata = ref_mem[0][8'h30];
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [5:1] ack_hist;
        d = $urandom;
        req = 1'b1; we = 1'b1; addr = 21'h00004; wdata = d; be = 4'hF;
        ack_hist = '0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            ack_hist[c] = ack;
            if (c == 3) we = 1'b0;
            if (c == 4) req = 1'b0;
        end
        ref_write(21'h00004, d, 4'hF);
        n_checks++; if (ack_hist !== 5'b10100) begin $display("FAIL b2b_ack_cycles: got %b want 10100", ack_hist); n_fail++; end
        n_checks++; if (rdata !== d) begin $display("FAIL b2b_rdata: got %h want %h", rdata, d); n_fail++; end
        exp_rdata = d;
    endtask

    task automatic test_slow_waits();
        logic [10:1] oe_hist, ack_hist;
        logic [6:1] we_hist, ce_hist, wack_hist;
        logic [DW-1:0] rd;
        s_req = 1'b1; s_we = 1'b0; s_addr = 21'h00005; s_be = '0;
        oe_hist = '0; ack_hist = '0; rd = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            s_req = (c == 2);
            oe_hist[c] = ~s_base_oe_n;
            ack_hist[c] = s_ack;
            if (s_ack) rd = s_rdata;
        end
        s_req = 1'b0;
        n_checks++; if (oe_hist !== 10'b0000000111) begin $display("FAIL slow_rd_oe: got %b want 0000000111", oe_hist); n_fail++; end
        n_checks++; if (ack_hist !== 10'b0000001000) begin $display("FAIL slow_rd_single_ack: got %b want 0000001000", ack_hist); n_fail++; end
        n_checks++; if (rd !== 32'h5A5A0005) begin $display("FAIL slow_rd_data: got %h want 5a5a0005", rd); n_fail++; end
        s_req = 1'b1; s_we = 1'b1; s_addr = 21'h00007; s_wdata = $urandom; s_be = 4'hF;
        we_hist = '0; ce_hist = '0; wack_hist = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            s_req = 1'b0;
            we_hist[c] = ~s_base_we_n;
            ce_hist[c] = ~s_base_ce_n;
            wack_hist[c] = s_ack;
        end
        n_checks++; if ({we_hist, ce_hist, wack_hist} !== {6'b000011, 6'b000111, 6'b001000}) begin
            $display("FAIL slow_wr_timing: got %b/%b/%b want 000011/000111/001000", we_hist, ce_hist, wack_hist); n_fail++; end
    endtask

    task automatic test_reset_mid();
        int acks, lat; logic [DW-1:0] rd;
        req = 1'b1; we = 1'b1; addr = 21'h00008; wdata = 32'h0BADF00D; be = 4'hF;
        @(posedge clk); #1; req = 1'b0;
        n_checks++; if ({base_ce_n, base_we_n} !== 2'b00) begin $display("FAIL rstmid_active: got %b want 00", {base_ce_n, base_we_n}); n_fail++; end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({base_ce_n, base_oe_n, base_we_n, base_be_n, busy} !== 8'hFE) begin
            $display("FAIL rstmid_async_strobes: got %b want 11111110", {base_ce_n, base_oe_n, base_we_n, base_be_n, busy}); n_fail++; end
        n_checks++; if (base_data === 32'h0BADF00D) begin $display("FAIL rstmid_bus_release: got %h want undriven", base_data); n_fail++; end
        @(posedge clk); #1; rst = 1'b1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        n_checks++; if (acks !== 0 || rdata !== '0) begin $display("FAIL rstmid_no_ack: got %0d acks rdata %h want 0/0", acks, rdata); n_fail++; end
        issue(1'b0, 21'h00008, '0, '0, lat, rd);
        n_checks++; if (lat !== 2 || rd !== ref_mem[0][8'h08]) begin
            $display("FAIL rstmid_read_after: got %0d/%h want 2/%h", lat, rd, ref_mem[0][8'h08]); n_fail++; end
        exp_rdata = ref_mem[0][8'h08];
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d, rd, exp;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic w;
        int lat;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            a = {1'($urandom_range(0, 1)), 12'h000, 8'($urandom_range(0, 15))};
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            if (!w) exp_q.push_back(ref_mem[a[AW-1]][a[7:0]]);
            issue(w, a, d, b, lat, rd);
            if (w) begin
                ref_write(a, d, b);
                n_checks++; if (lat !== 3 || rd !== exp_rdata) begin
                    $display("FAIL rand_wr_%0d: got %0d/%h want 3/%h", n, lat, rd, exp_rdata); n_fail++; end
            end else begin
                exp = exp_q.pop_front();
                n_checks++; if (lat !== 2 || rd !== exp) begin
                    $display("FAIL rand_rd_%0d addr %h: got %0d/%h want 2/%h", n, a, lat, rd, exp); n_fail++; end
                exp_rdata = exp;
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            base_mem[i] = '0; ext_mem[i] = '0;
            ref_mem[0][i] = '0; ref_mem[1][i] = '0;
        end
        test_reset();
        test_write_base();
        test_read_base();
        test_ext_partial();
        test_zero_be();
        test_back_to_back();
        test_slow_waits();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised dual-bank asynchronous-SRAM controller that sits between the MEM stage's data port and the on-board base/extension SRAM chips. It generalises the single-width word driver with configurable address and data width, per-operation wait states, byte-lane enables, a write hold cycle and a registered read-data path. Completion is signalled with a one-cycle `ack` pulse, and `busy` is provided for pipeline stalling.

## Interface
Parameters:
- `ADDR_W`, 21: word-address width; MSB selects the bank (0 = base, 1 = ext).
- `DATA_W`, 32: data width; must be a multiple of 8.
- `RD_WAIT`, 1: cycles OE is held active per read; 0 is treated as 1.
- `WR_WAIT`, 1: cycles WE is held active per write; 0 is treated as 1.

Ports:
- `clk`  in  1  single clock; every register is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `be`  in  DATA_W/8  byte enables for writes; ignored on reads.
- `rdata`  out  DATA_W  registered read data.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `base_addr`, `ext_addr`  out  ADDR_W-1  chip address.
- `base_data`, `ext_data`  inout  DATA_W  chip data bus.
- `base_ce_n`, `base_oe_n`, `base_we_n`, `ext_ce_n`, `ext_oe_n`, `ext_we_n`  out  1  active-low chip strobes.
- `base_be_n`, `ext_be_n`  out  DATA_W/8  active-low byte lanes.

## Operation
- States: IDLE, ACCESS, HOLD.
- IDLE, `req`=1: latch `addr`, `we`, `wdata` and `be`. Load the wait counter with WAIT-1, where WAIT is `RD_WAIT` or `WR_WAIT`, then go to ACCESS.
- ACCESS: the selected bank drives `ce_n`=0 and `addr[ADDR_W-2:0]`.
  - Read: `oe_n`=0, `we_n`=1, `be_n`=all 0.
  - Write: `oe_n`=1, `we_n`=0, `be_n`=~`be`.
  - The counter decrements each cycle. When it reaches 0:
    - Read: `rdata` ← bank data bus, `ack` ← 1, go to IDLE.
    - Write: go to HOLD.
- HOLD (write only): `we_n`=1, `ce_n`=0, data still driven. Then `ack` ← 1, go to IDLE.
- Unselected bank: all strobes and `be_n` are high and its data bus is Z for the whole transaction.
- Data bus drive: a bank's data bus is driven only when that bank is selected, the operation is a write, and state is ACCESS or HOLD. Otherwise it is Z.
- Write with `be`=0: the transaction runs its full length with `ce_n` low, but `we_n` is never asserted. `ack` is still pulsed.
- `req` while `busy`=1: ignored, not queued.
- `rdata` holds its value until the next read completes. Writes do not change it.
- All strobe, address, `be_n` and `ack` outputs are registered, so they are glitch-free.

## Timing
- Cycle 0 is the edge at which `req` is sampled in IDLE. Strobes become active from cycle 1.
- Read: `ack` and valid `rdata` appear in cycle 1+`RD_WAIT`. Latency is `RD_WAIT`+1.
- Write: `we_n` is low in cycles 1..`WR_WAIT` and HOLD is cycle `WR_WAIT`+1. `ack` appears in cycle `WR_WAIT`+2.
- The `ack` cycle is an IDLE cycle, so a `req` sampled there is accepted. This gives back-to-back transactions with no gap.
- Reset values, applied immediately on `rst`=0 regardless of clock:
  - state IDLE, `ack`=0, `busy`=0, `rdata`=0.
  - All `ce_n`/`oe_n`/`we_n`/`be_n` = 1.
  - Addresses = 0, data buses Z.
- Reset mid-transaction aborts the transaction. No `ack` is issued after release, and the first post-reset `req` is handled normally.

## Test plan
- Write 0x00010 ← 0xDEADBEEF, `be`=0xF, defaults.
  - Cycle 1: `base_ce_n`=`base_we_n`=0, `base_be_n`=0x0.
  - Cycle 2: `we_n`=1 with data still driven.
  - Cycle 3: `ack`=1.
  - All ext strobes stay 1.
- Read 0x00010 with an SRAM model holding 0xDEADBEEF → `base_oe_n`=0 in cycle 1; in cycle 2, `ack`=1 and `rdata`=0xDEADBEEF; data bus never driven by the controller.
- Write 0x100020 ← 0x12345678, `be`=0x3 → `ext_addr`=0x00020, `ext_be_n`=0xC. Reading 0x100020 returns 0xXXXX5678, where the upper bytes are the prior contents. Base strobes stay 1.
- `RD_WAIT`=3 instance, read → `oe_n` low in cycles 1–3 and `ack` in cycle 4. A second `req` pulsed in cycle 2 is ignored: exactly one `ack`.
- `req` held high, alternating write/read to 0x00004 → second transaction accepted in the first `ack` cycle. Acks land in cycles 3 and 5, and `rdata` equals the written value.
- `rst` pulled low during cycle 1 of a write → strobes go high and the data bus goes Z without waiting for a clock edge. No `ack` follows, and a subsequent read completes normally.
